// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between two requesters and the shared saturating
// add/subtract unit. The requester side drives operands and accepts results.
interface addsub_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_sub;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_sub;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [15:0] rsp_sum;
    logic        rsp_ovfl;

    logic [7:0]  ovfl_count;
    logic        ovfl_clr;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp0_ready, rsp1_ready, ovfl_clr,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_sum, rsp_ovfl, ovfl_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp0_ready, rsp1_ready, ovfl_clr,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_sum, rsp_ovfl, ovfl_count
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter in front of a single saturating 16-bit add/subtract
// unit. One operation in flight at a time: IDLE (grant) -> EXEC (compute)
// -> RESP (hold result until the winner takes it).
module addsub_arbiter (
    input  logic               clk,
    input  logic               rst,
    addsub_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               winner_q, winner_d;

    logic signed [15:0] op_a_q;
    logic signed [15:0] op_b_q;
    logic               op_cin_q;

    logic signed [15:0] rsp_sum_q;
    logic               rsp_ovfl_q;
    logic [7:0]         ovfl_count_q, ovfl_count_d;

    logic               grant0, grant1, accept;
    logic signed [15:0] sum_raw;
    logic               sum_ovfl;

    // Signed overflow of a + b + cin: operands share a sign the result lacks.
    function automatic logic add_ovfl(input logic signed [15:0] a,
                                      input logic signed [15:0] b,
                                      input logic signed [15:0] raw);
        return (a[15] == b[15]) && (raw[15] != a[15]);
    endfunction

    // Clamp on overflow; a wrapped-positive MSB means the true result was negative.
    function automatic logic signed [15:0] sat16(input logic signed [15:0] raw,
                                                 input logic               ovfl);
        if (!ovfl)
            return raw;
        else if (raw[15])
            return 16'sh7FFF;
        else
            return 16'sh8000;
    endfunction

    // Tie goes to the requester not granted last; a lone requester always wins.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        accept = (state_q == IDLE) && (grant0 || grant1);
    end

    // Next-state logic and handshake outputs; rst masks outputs so none glitch high.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        winner_d       = winner_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req0_ready = grant0 && !rst;
                bus.req1_ready = grant1 && !rst;
                if (accept) begin
                    winner_d     = grant1;
                    last_grant_d = grant1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                bus.rsp0_valid = !winner_q && !rst;
                bus.rsp1_valid =  winner_q && !rst;
                if (winner_q ? bus.rsp1_ready : bus.rsp0_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM, fairness pointer and recorded winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
        end
    end

    // Operand capture on acceptance; subtract is folded into ~B plus carry-in.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a_q   <= grant1 ? bus.req1_a : bus.req0_a;
            op_b_q   <= grant1 ? (bus.req1_sub ? ~bus.req1_b : bus.req1_b)
                               : (bus.req0_sub ? ~bus.req0_b : bus.req0_b);
            op_cin_q <= grant1 ? bus.req1_sub : bus.req0_sub;
        end
    end

    // The one shared adder, evaluated from the operand registers.
    always_comb begin
        sum_raw  = op_a_q + op_b_q + {15'd0, op_cin_q};
        sum_ovfl = add_ovfl(op_a_q, op_b_q, sum_raw);
    end

    // Result register, loaded once in EXEC and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_sum_q  <= 16'sh0000;
            rsp_ovfl_q <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_sum_q  <= sat16(sum_raw, sum_ovfl);
            rsp_ovfl_q <= sum_ovfl;
        end
    end

    // Overflow counter next value: clear beats increment, increment stops at 255.
    always_comb begin
        ovfl_count_d = ovfl_count_q;
        if (bus.ovfl_clr)
            ovfl_count_d = 8'd0;
        else if ((state_q == EXEC) && sum_ovfl && (ovfl_count_q != 8'hFF))
            ovfl_count_d = ovfl_count_q + 8'd1;
    end

    // Overflow counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovfl_count_q <= 8'd0;
        else
            ovfl_count_q <= ovfl_count_d;
    end

    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_ovfl   = rsp_ovfl_q;
    assign bus.ovfl_count = ovfl_count_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: single ops, saturation, contention,
// response backpressure, counter saturation/clear and reset mid-operation.
module tb_addsub_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    addsub_arbiter_if bus ();

    addsub_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rvld(input int p);
        return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic sub);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 0) bus.rsp0_ready = v;
        else        bus.rsp1_ready = v;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Full checked transaction on one port, ending back in IDLE.
    task automatic run_op(input string tag, input int p, input logic [15:0] a,
                          input logic [15:0] b, input logic sub,
                          input logic [15:0] esum, input logic eovfl);
        int n;
        set_req(p, 1'b1, a, b, sub);
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_ready"}, rdy(p), 1);
        check({tag, "_other_ready"}, rdy(1 - p), 0);
        tick;
        set_req(p, 1'b0, 16'h0, 16'h0, 1'b0);
        #1;
        check({tag, "_exec_no_rsp"}, rvld(p), 0);
        tick;
        check({tag, "_rsp_valid"}, rvld(p), 1);
        check({tag, "_other_rsp"}, rvld(1 - p), 0);
        check({tag, "_sum"}, bus.rsp_sum, esum);
        check({tag, "_ovfl"}, bus.rsp_ovfl, eovfl);
        set_rsp_ready(p, 1'b1);
        tick;
        set_rsp_ready(p, 1'b0);
        #1;
        check({tag, "_rsp_drop"}, rvld(p), 0);
    endtask

    // Unchecked transaction, only a stalled grant is reported.
    task automatic quick_op(input int p, input logic [15:0] a, input logic [15:0] b,
                            input logic sub);
        int n;
        set_req(p, 1'b1, a, b, sub);
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin
            tick;
            n++;
        end
        if (n >= 20) check("quick_grant_timeout", 0, 1);
        tick;
        set_req(p, 1'b0, 16'h0, 16'h0, 1'b0);
        tick;
        set_rsp_ready(p, 1'b1);
        tick;
        set_rsp_ready(p, 1'b0);
    endtask

    initial begin
        int   n;
        int   g;
        logic seen;
        logic [15:0] held;

        rst = 1'b1;
        set_req(0, 1'b1, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b1, 16'h0, 16'h0, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        bus.ovfl_clr   = 1'b0;
        tick;
        tick;
        // Reset state, with valids high to expose any ready glitch
        check("rst_req0_ready", bus.req0_ready, 0);
        check("rst_req1_ready", bus.req1_ready, 0);
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp1_valid", bus.rsp1_valid, 0);
        check("rst_sum", bus.rsp_sum, 16'h0000);
        check("rst_ovfl", bus.rsp_ovfl, 0);
        check("rst_count", bus.ovfl_count, 8'd0);
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b0;
        tick;

        // Single add and saturating subtracts
        run_op("add0", 0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);
        check("add0_count", bus.ovfl_count, 8'd0);
        run_op("negsat1", 1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);
        check("negsat1_count", bus.ovfl_count, 8'd1);
        run_op("possat1", 1, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
        check("possat1_count", bus.ovfl_count, 8'd2);
        run_op("nosat_sub", 0, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0);
        run_op("possat_add", 0, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
        check("possat_add_count", bus.ovfl_count, 8'd3);

        // Contention from reset: alternate 0,1,0,1; other rsp_ready ignored
        apply_reset;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(0, 1'b1, 16'h1000, 16'h0001, 1'b0);
        set_req(1, 1'b1, 16'h0010, 16'h0020, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            n = 0;
            while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
                tick;
                #1;
                n++;
            end
            g = k % 2;
            check("cont_grant", rdy(g), 1);
            check("cont_not_grant", rdy(1 - g), 0);
            tick;
            #1;
            check("cont_exec_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
            tick;
            #1;
            check("cont_rsp_own", rvld(g), 1);
            check("cont_rsp_other", rvld(1 - g), 0);
            check("cont_sum", bus.rsp_sum, (g == 0) ? 16'h1001 : 16'hFFF0);
            tick;
        end
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        tick;

        // Response backpressure on port 0 while port 1 waits
        apply_reset;
        set_req(0, 1'b1, 16'h0100, 16'h0200, 1'b0);
        #1;
        check("bp_ready0", bus.req0_ready, 1);
        tick;
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick;
        set_req(1, 1'b1, 16'h0005, 16'h0003, 1'b1);
        #1;
        held = bus.rsp_sum;
        check("bp_sum", held, 16'h0300);
        for (int k = 0; k < 5; k++) begin
            check("bp_req1_blocked", bus.req1_ready, 0);
            check("bp_rsp0_held", bus.rsp0_valid, 1);
            check("bp_sum_stable", bus.rsp_sum, held);
            tick;
            #1;
        end
        bus.rsp0_ready = 1'b1;
        tick;
        bus.rsp0_ready = 1'b0;
        #1;
        check("bp_rsp0_done", bus.rsp0_valid, 0);
        check("bp_req1_ready", bus.req1_ready, 1);
        tick;
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        #1;
        check("bp_rsp1_exec", bus.rsp1_valid, 0);
        tick;
        check("bp_rsp1_valid", bus.rsp1_valid, 1);
        check("bp_rsp1_sum", bus.rsp_sum, 16'h0002);
        bus.rsp1_ready = 1'b1;
        tick;
        bus.rsp1_ready = 1'b0;

        // Counter saturates at 255
        apply_reset;
        for (int k = 0; k < 260; k++)
            quick_op(k % 2, 16'h7FFF, 16'h0001, 1'b0);
        #1;
        check("cnt_saturated", bus.ovfl_count, 8'hFF);

        // Clear coinciding with an overflowing EXEC wins
        set_req(0, 1'b1, 16'h8000, 16'hFFFF, 1'b0);
        #1;
        n = 0;
        while (!bus.req0_ready && n < 20) begin
            tick;
            n++;
        end
        check("clr_ready", bus.req0_ready, 1);
        tick;
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        bus.ovfl_clr = 1'b1;
        tick;
        bus.ovfl_clr = 1'b0;
        #1;
        check("clr_count", bus.ovfl_count, 8'd0);
        check("clr_sum", bus.rsp_sum, 16'h8000);
        check("clr_ovfl", bus.rsp_ovfl, 1);
        bus.rsp0_ready = 1'b1;
        tick;
        bus.rsp0_ready = 1'b0;
        run_op("after_clr", 1, 16'h7000, 16'h1000, 1'b0, 16'h7FFF, 1'b1);
        check("after_clr_count", bus.ovfl_count, 8'd1);

        // Async reset during EXEC discards the op
        set_req(1, 1'b1, 16'h7FFF, 16'h0002, 1'b0);
        #1;
        n = 0;
        while (!bus.req1_ready && n < 20) begin
            tick;
            n++;
        end
        check("ar_ready", bus.req1_ready, 1);
        tick;
        set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_req0_ready", bus.req0_ready, 0);
        check("ar_req1_ready", bus.req1_ready, 0);
        check("ar_rsp0", bus.rsp0_valid, 0);
        check("ar_rsp1", bus.rsp1_valid, 0);
        check("ar_sum", bus.rsp_sum, 16'h0000);
        check("ar_ovfl", bus.rsp_ovfl, 0);
        check("ar_count", bus.ovfl_count, 8'd0);
        tick;
        check("ar_held_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            seen = seen | bus.rsp0_valid | bus.rsp1_valid;
        end
        check("ar_no_rsp_after", seen, 0);
        check("ar_count_after", bus.ovfl_count, 8'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
        set_req(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
        #1;
        check("ar_tie_req0", bus.req0_ready, 1);
        check("ar_tie_req1", bus.req1_ready, 0);
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        tick;
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick;
        check("ar_recover_rsp", bus.rsp0_valid, 1);
        check("ar_recover_sum", bus.rsp_sum, 16'h0002);
        bus.rsp0_ready = 1'b1;
        tick;
        bus.rsp0_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
